stack_unit: RTL
===============

Name: stack_unit

Overview:
- Parametrised stack engine: stack pointer, occupancy tracking and stack RAM in one block.
- Successor to the fixed 8-bit pointer register. Adds configurable width and depth, PUSH/POP semantics with integrated storage, full/empty flags, and sticky overflow/underflow errors.
- Sits beside the RAT CPU control unit. CALL/PUSH drive PUSH; RET/POP drive POP; MOV SP drives LD.

Parameters:
- DATA_W, 8, width of each stack entry.
- DEPTH, 256, number of entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- LD  in  1  load stack pointer from D_IN.
- D_IN  in  PTR_W  new stack pointer value for LD.
- PUSH  in  1  push request.
- POP  in  1  pop request.
- PUSH_DATA  in  DATA_W  data written on push.
- ERR_CLR  in  1  clear sticky OVF/UNF.
- POP_DATA  out  DATA_W  registered pop result.
- POP_VALID  out  1  one-cycle pulse: POP_DATA updated this cycle.
- SP_OUT  out  PTR_W  current stack pointer.
- OCC  out  PTR_W+1  current entry count, 0..DEPTH.
- EMPTY  out  1  OCC == 0; combinational from registered state.
- FULL  out  1  OCC == DEPTH; combinational from registered state.
- OVF  out  1  sticky: push attempted while full.
- UNF  out  1  sticky: pop attempted while empty.

Behaviour:
- Stack grows downward.
  - Push: writes mem[SP-1], then SP <= SP-1, OCC <= OCC+1.
  - Pop: reads mem[SP], then SP <= SP+1, OCC <= OCC-1.
  - All pointer arithmetic is modulo DEPTH (PTR_W-bit wrap, e.g. 0-1 = DEPTH-1).
- Reset, checked first each edge:
  - SP=0, OCC=0, POP_DATA=0, POP_VALID=0, OVF=0, UNF=0.
  - RAM contents are not reset.
  - RST mid-sequence discards any same-cycle PUSH/POP/LD.
- Command priority per edge: RST > LD > (PUSH & POP) > PUSH > POP.
- LD:
  - SP <= D_IN, OCC <= 0 (stack re-based empty). No RAM write.
  - Same-cycle PUSH/POP are ignored and do not set error flags.
- PUSH alone:
  - Not full: mem[SP-1] <= PUSH_DATA; SP and OCC update as above.
  - Full: no write, SP/OCC unchanged, OVF <= 1.
- POP alone:
  - Not empty: POP_DATA <= mem[SP]; POP_VALID=1 next cycle; SP and OCC update as above.
  - Empty: POP_DATA holds, POP_VALID=0, SP/OCC unchanged, UNF <= 1.
- PUSH and POP together (replace-top):
  - Not empty: POP_DATA <= mem[SP] (old top); mem[SP] <= PUSH_DATA; SP/OCC unchanged; POP_VALID=1. Legal when full.
  - Empty: bypass. POP_DATA <= PUSH_DATA, POP_VALID=1, no RAM write, no state change, no error.
- Latency:
  - POP_DATA/POP_VALID are valid on the edge after the POP request.
  - A push followed by a pop on the next cycle returns the pushed value (no read-before-write hazard).
- POP_VALID is deasserted in every cycle not covered by the rules above. POP_DATA otherwise holds its last value.
- ERR_CLR clears OVF and UNF. If a new error occurs in the same cycle, set wins.
- EMPTY/FULL reflect registered OCC only, not same-cycle requests.

Test Plan:
(All scenarios use DATA_W=8, DEPTH=4.)
- Reset, then push 0x11, 0x22, 0x33, 0x44 -> SP steps 0→3→2→1→0, OCC=4, FULL=1. Fifth push 0x55 -> OCC=4, SP=0, OVF=1, no data corruption.
- From full, pop 4 times -> POP_DATA 0x44, 0x33, 0x22, 0x11, each with a POP_VALID pulse one cycle after request; EMPTY=1. Fifth pop -> POP_VALID=0, UNF=1, POP_DATA stays 0x11.
- Push 0xA5, then PUSH+POP with 0x5A -> POP_DATA=0xA5, OCC=1. Following pop -> 0x5A. PUSH+POP on empty with 0x77 -> POP_DATA=0x77, OCC=0, no UNF.
- With OCC=2, LD with D_IN=2 plus a simultaneous PUSH -> SP=2, OCC=0, EMPTY=1, no RAM write, no OVF. Next push 0x99 writes entry 1, SP=1.
- OVF=1, then ERR_CLR together with a push while full -> OVF stays 1. ERR_CLR alone -> OVF=0, UNF=0.
- Push twice, assert RST with POP the same cycle -> SP=0, OCC=0, POP_VALID=0, all flags 0.

Source files
------------

// File: rtl/stack_unit.sv
// Parametrised downward-growing stack: pointer, occupancy, storage, pop result register
// and sticky overflow/underflow flags.
module stack_unit #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LD,
   input  logic [PTR_W-1:0]  D_IN,
   input  logic              PUSH,
   input  logic              POP,
   input  logic [DATA_W-1:0] PUSH_DATA,
   input  logic              ERR_CLR,
   output logic [DATA_W-1:0] POP_DATA,
   output logic              POP_VALID,
   output logic [PTR_W-1:0]  SP_OUT,
   output logic [PTR_W:0]    OCC,
   output logic              EMPTY,
   output logic              FULL,
   output logic              OVF,
   output logic              UNF
);

   localparam int unsigned OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0]  sp_q, sp_d, sp_dec, sp_inc;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [DATA_W-1:0] pop_data_q, pop_data_d;
   logic              pop_valid_q, pop_valid_d;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              set_ovf, set_unf;
   logic              mem_we;
   logic [PTR_W-1:0]  mem_wa;
   logic              empty_c, full_c;

   assign empty_c = (occ_q == '0);
   assign full_c  = (occ_q == OCC_MAX);
   assign sp_dec  = sp_q - PTR_W'(1);
   assign sp_inc  = sp_q + PTR_W'(1);

   // Next-state decode; priority LD > replace-top > PUSH > POP (RST applied in the register).
   always_comb begin
      sp_d        = sp_q;
      occ_d       = occ_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      set_ovf     = 1'b0;
      set_unf     = 1'b0;
      mem_we      = 1'b0;
      mem_wa      = sp_q;

      if (LD) begin
         sp_d  = D_IN;
         occ_d = '0;
      end else if (PUSH && POP) begin
         // Empty stack bypasses the RAM: pushed value is returned directly.
         pop_valid_d = 1'b1;
         if (empty_c) begin
            pop_data_d = PUSH_DATA;
         end else begin
            pop_data_d = mem[sp_q];
            mem_we     = 1'b1;
            mem_wa     = sp_q;
         end
      end else if (PUSH) begin
         if (full_c) begin
            set_ovf = 1'b1;
         end else begin
            mem_we = 1'b1;
            mem_wa = sp_dec;
            sp_d   = sp_dec;
            occ_d  = occ_q + OCC_W'(1);
         end
      end else if (POP) begin
         if (empty_c) begin
            set_unf = 1'b1;
         end else begin
            pop_data_d  = mem[sp_q];
            pop_valid_d = 1'b1;
            sp_d        = sp_inc;
            occ_d       = occ_q - OCC_W'(1);
         end
      end

      ovf_d = (ovf_q & ~ERR_CLR) | set_ovf;
      unf_d = (unf_q & ~ERR_CLR) | set_unf;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sp_q        <= '0;
         occ_q       <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         occ_q       <= occ_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // Storage is not reset; writes are suppressed while RST is asserted.
   always_ff @(posedge CLK) begin
      if (mem_we && !RST) begin
         mem[mem_wa] <= PUSH_DATA;
      end
   end

   assign POP_DATA  = pop_data_q;
   assign POP_VALID = pop_valid_q;
   assign SP_OUT    = sp_q;
   assign OCC       = occ_q;
   assign EMPTY     = empty_c;
   assign FULL      = full_c;
   assign OVF       = ovf_q;
   assign UNF       = unf_q;

endmodule
